vector_execute_unit: RTL and testbench
======================================

# vector_execute_unit

Parametrised, time-multiplexed vector execute stage for the SIMD pipeline. Processes a `vecSize`-lane operation on `laneCount` physical ALUs over `vecSize/laneCount` beats, with valid/ready handshakes on both sides. It keeps architectural N/Z flags and resolves conditional PC writes. A synchronous `flush` cancels an in-flight operation before it commits.

## Interface
- `regSize`, default 32: lane width in bits.
- `vecSize`, default 4: lanes per vector.
- `laneCount`, default 2: physical ALUs; must divide `vecSize`, ≥1. Beats `B = vecSize/laneCount`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous cancel of the in-flight operation.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: unit can accept.
- `ExecuteOp` in 3: opcode.
- `overwriteFlags` in 1: commit N/Z from this operation.
- `pcWrEn` in 3: branch condition select.
- `vect1`, `vect2` in `[vecSize-1:0][regSize-1:0]`: operand vectors.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `vectOut` out `[vecSize-1:0][regSize-1:0]`: result vector, registered.
- `pcWrEnOut` out 1: branch taken, qualified by `out_valid`.
- `flagsOut` out 2: architectural `{Z,N}`.

## Operation
- **Opcodes.** 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- 101 SLL and 110 SRL shift operand1 by operand2[`$clog2(regSize)`-1:0].
- 111 MUL returns the low `regSize` bits of the product.
- All arithmetic wraps modulo 2^regSize.
- **Capture.** On `in_valid & in_ready` the unit latches operands, `ExecuteOp`, `overwriteFlags` and `pcWrEn`. Input ports may then change freely.
- **FSM: IDLE → BUSY → DONE → IDLE.**
- IDLE: `in_ready = ~flush`. A handshake moves the FSM to BUSY with beat counter 0.
- BUSY: each cycle computes lanes `[beat*laneCount +: laneCount]` into `vectOut` and increments the counter.
- BUSY → DONE: after the beat with counter = B−1.
- DONE: `out_valid = 1`, held stable until `out_ready`. DONE & `out_ready` → IDLE.
- **Pending flags.** Computed across beats:
  - pendN = OR of the result MSBs of all lanes.
  - pendZ = AND of (result == 0) over all lanes.
  - Lanes not yet computed do not contribute.
- **Commit.** On the output handshake, if the latched `overwriteFlags` is set, `flagsOut` ← `{pendZ,pendN}`. Otherwise `flagsOut` is unchanged.
- **Branch.** While in DONE, the effective flags are the pending flags if `overwriteFlags` is latched, else `flagsOut`.
- `pcWrEn` 100 → `pcWrEnOut = ~Z`; 010 → Z; 001 → N; any other value → 0.
- `pcWrEnOut` is 0 whenever `out_valid` is 0.
- **Flush.**
  - In BUSY or DONE: next state is IDLE, no flag commit, `out_valid` drops the next cycle, `vectOut` keeps its stale value.
  - In IDLE: blocks acceptance that cycle.
  - Flush has priority over `out_ready`.
- **Reset.**
  - Outputs: `vectOut` = 0, `flagsOut` = 00, `out_valid` = 0, `pcWrEnOut` = 0.
  - FSM goes to IDLE, which gives `in_ready` = 1 once `flush` is 0.
  - Pending flags are cleared.
  - Reset mid-operation discards the operation.

## Timing
- Accept at edge E0. BUSY spans cycles E0..E0+B−1. `out_valid` rises after edge E0+B, giving latency B cycles; B = 1 when `laneCount = vecSize`.
- Throughput is one operation per B+1 cycles with `out_ready` tied high. There is no accept in the DONE→IDLE cycle.
- `flagsOut` updates at the output-handshake edge. An operation accepted afterwards sees the new flags.
- Back-pressure: DONE may last indefinitely. `vectOut`, `out_valid` and `pcWrEnOut` stay stable throughout.
- `in_ready`, `out_valid` and `pcWrEnOut` come from registered state only. `flush` also gates `in_ready` combinationally.

## Test plan
- **Reset mid-op.** Assert `reset` during BUSY → all outputs 0 and `in_ready` = 1 immediately. The next operation completes normally.
- **ADD with wrap, defaults.** vect1 = {1, 0xFFFFFFFF, 5, 7}, vect2 = {1, 1, 0xFFFFFFFB, 0}, `overwriteFlags` = 1.
  - `out_valid` is high 2 cycles after accept; `vectOut` = {2, 0, 0, 7}.
  - After handshake, `flagsOut` = 00.
- **Z-branch.** SUB of equal vectors {3,3,3,3}−{3,3,3,3}, `pcWrEn` = 010 → `pcWrEnOut` = 1 in DONE; `flagsOut` = 10 after `out_ready`.
  - Same op with `pcWrEn` = 100 → `pcWrEnOut` = 0.
- **N without overwrite.** SUB {0,…}−{1,…}, `overwriteFlags` = 0, `pcWrEn` = 001, prior `flagsOut` = 00 → `pcWrEnOut` = 0 and `flagsOut` unchanged.
- **Flush in DONE.** With `out_ready` = 0, assert `flush` → `out_valid` = 0 next cycle, `flagsOut` unchanged, `in_ready` = 1.
- **Parameter sweep.** `laneCount` ∈ {1, 2, 4}, MUL {0x10000,…}×{0x10000,…} → all lanes 0 and Z = 1; latency 4/2/1 cycles respectively.
  - SLL by 33 with `regSize` = 32 shifts by 1.

Source files
------------

// File: rtl/vector_execute_unit.sv
// Time-multiplexed SIMD execute stage: vecSize lanes on laneCount ALUs over
// vecSize/laneCount beats, with N/Z flag commit and branch resolution.

module vector_execute_lane #(
  parameter int regSize = 32
) (
  input  logic [2:0]         i_op,
  input  logic [regSize-1:0] i_a,
  input  logic [regSize-1:0] i_b,
  output logic [regSize-1:0] o_res
);
  localparam int SH = $clog2(regSize);

  logic [SH-1:0] w_sh;
  assign w_sh = i_b[SH-1:0];

  always_comb begin
    o_res = '0;
    case (i_op)
      3'b000:  o_res = i_a + i_b;
      3'b001:  o_res = i_a - i_b;
      3'b010:  o_res = i_a & i_b;
      3'b011:  o_res = i_a | i_b;
      3'b100:  o_res = i_a ^ i_b;
      3'b101:  o_res = i_a << w_sh;
      3'b110:  o_res = i_a >> w_sh;
      default: o_res = i_a * i_b;
    endcase
  end
endmodule

module vector_execute_unit #(
  parameter int regSize   = 32,
  parameter int vecSize   = 4,
  parameter int laneCount = 2
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_flush,
  input  logic                            i_in_valid,
  output logic                            o_in_ready,
  input  logic [2:0]                      i_ExecuteOp,
  input  logic                            i_overwriteFlags,
  input  logic [2:0]                      i_pcWrEn,
  input  logic [vecSize-1:0][regSize-1:0] i_vect1,
  input  logic [vecSize-1:0][regSize-1:0] i_vect2,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [vecSize-1:0][regSize-1:0] o_vectOut,
  output logic                            o_pcWrEnOut,
  output logic [1:0]                      o_flagsOut
);
  localparam int B  = vecSize / laneCount;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_next;

  logic [BW-1:0] r_beat;
  logic [2:0]    r_op, r_pcsel;
  logic          r_ovf, r_pendN, r_pendZ;
  logic [1:0]    r_flags;
  // Viewed as [beat][lane-in-beat] so lane beat*laneCount+j is a plain select.
  logic [B-1:0][laneCount-1:0][regSize-1:0] r_v1, r_v2, r_vout;

  logic [laneCount-1:0][regSize-1:0] w_res;
  logic [laneCount-1:0]              w_msb, w_zero;
  logic w_accept, w_last, w_commit, w_effN, w_effZ;

  for (genvar j = 0; j < laneCount; j++) begin : g_lane
    vector_execute_lane #(.regSize(regSize)) u_lane (
      .i_op  (r_op),
      .i_a   (r_v1[r_beat][j]),
      .i_b   (r_v2[r_beat][j]),
      .o_res (w_res[j])
    );
    assign w_msb[j]  = w_res[j][regSize-1];
    assign w_zero[j] = (w_res[j] == '0);
  end

  assign o_in_ready = (r_state == S_IDLE) & ~i_flush;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_last     = (r_beat == BW'(B - 1));
  assign w_commit   = (r_state == S_DONE) & i_out_ready & ~i_flush;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_BUSY;
      S_BUSY: begin
        if (i_flush)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE: if (i_flush || i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_beat  <= '0;
      r_op    <= '0;
      r_pcsel <= '0;
      r_ovf   <= 1'b0;
      r_pendN <= 1'b0;
      r_pendZ <= 1'b0;
      r_flags <= '0;
      r_v1    <= '0;
      r_v2    <= '0;
      r_vout  <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= i_ExecuteOp;
        r_ovf   <= i_overwriteFlags;
        r_pcsel <= i_pcWrEn;
        r_v1    <= i_vect1;
        r_v2    <= i_vect2;
        r_beat  <= '0;
        r_pendN <= 1'b0;
        r_pendZ <= 1'b1;
      end
      // A flushed beat leaves the previous result vector untouched.
      if (r_state == S_BUSY && !i_flush) begin
        r_vout[r_beat] <= w_res;
        r_beat         <= w_last ? '0 : r_beat + 1'b1;
        r_pendN        <= r_pendN | (|w_msb);
        r_pendZ        <= r_pendZ & (&w_zero);
      end
      if (w_commit && r_ovf) r_flags <= {r_pendZ, r_pendN};
    end
  end

  assign o_vectOut   = r_vout;
  assign o_flagsOut  = r_flags;
  assign o_out_valid = (r_state == S_DONE);
  assign w_effZ      = r_ovf ? r_pendZ : r_flags[1];
  assign w_effN      = r_ovf ? r_pendN : r_flags[0];

  always_comb begin
    o_pcWrEnOut = 1'b0;
    if (o_out_valid) begin
      case (r_pcsel)
        3'b100:  o_pcWrEnOut = ~w_effZ;
        3'b010:  o_pcWrEnOut = w_effZ;
        3'b001:  o_pcWrEnOut = w_effN;
        default: o_pcWrEnOut = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_execute_unit.sv
// Bench for vector_execute_unit: three instances (laneCount 1/2/4) driven in
// lockstep and compared against a lane-wise arithmetic reference model.

module tb_vector_execute_unit;
  localparam int RS = 32;
  localparam int VS = 4;
  localparam int W  = RS * VS;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, ovf;
  logic [2:0] op, pcsel;
  logic [VS-1:0][RS-1:0] v1, v2;

  logic ir [3];
  logic ov [3];
  logic pco [3];
  logic [1:0] fo [3];
  logic [VS-1:0][RS-1:0] vo [3];

  int checks = 0;
  int errors = 0;
  logic [1:0] mflags;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vector_execute_unit #(.regSize(RS), .vecSize(VS), .laneCount(1 << g)) dut (
      .i_clk(clk), .i_reset(rst), .i_flush(flush),
      .i_in_valid(in_valid), .o_in_ready(ir[g]),
      .i_ExecuteOp(op), .i_overwriteFlags(ovf), .i_pcWrEn(pcsel),
      .i_vect1(v1), .i_vect2(v2),
      .o_out_valid(ov[g]), .i_out_ready(out_ready),
      .o_vectOut(vo[g]), .o_pcWrEnOut(pco[g]), .o_flagsOut(fo[g])
    );
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RS-1:0] alu(input logic [2:0] o, input logic [RS-1:0] a, b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << (b % RS);
      3'd6: return a >> (b % RS);
      default: return a * b;
    endcase
  endfunction

  task automatic model(input logic [2:0] o, input logic [VS-1:0][RS-1:0] a, b,
                       output logic [VS-1:0][RS-1:0] ev, output logic n, output logic z);
    n = 1'b0;
    z = 1'b1;
    for (int k = 0; k < VS; k++) begin
      ev[k] = alu(o, a[k], b[k]);
      if (ev[k][RS-1]) n = 1'b1;
      if (ev[k] != 0)  z = 1'b0;
    end
  endtask

  function automatic logic branch(input logic [2:0] sel, input logic zf, input logic nf);
    if (sel == 3'b100) return !zf;
    if (sel == 3'b010) return zf;
    if (sel == 3'b001) return nf;
    return 1'b0;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, wait for the accepting edge, then scramble inputs.
  task automatic start(input logic [2:0] o, input logic [VS-1:0][RS-1:0] a, b,
                       input logic f, input logic [2:0] p);
    op = o; v1 = a; v2 = b; ovf = f; pcsel = p; in_valid = 1'b1;
    chk("in_ready_before_accept", W'(ir[1]), W'(1));
    cycle();
    in_valid = 1'b0;
    op = 3'($urandom); ovf = 1'($urandom); pcsel = 3'($urandom);
    for (int k = 0; k < VS; k++) begin
      v1[k] = $urandom;
      v2[k] = $urandom;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [VS-1:0][RS-1:0] a, b,
                        input logic f, input logic [2:0] p);
    logic [VS-1:0][RS-1:0] ev;
    logic n, z, epc;
    int lat [3];
    model(o, a, b, ev, n, z);
    epc = f ? branch(p, z, n) : branch(p, mflags[1], mflags[0]);
    start(o, a, b, f, p);
    lat = '{0, 0, 0};
    for (int c = 1; c <= 20 && !(ov[0] && ov[1] && ov[2]); c++) begin
      cycle();
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] == 0) lat[d] = c;
    end
    cycle();  // extra back-pressure cycle: outputs must hold
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_latency%0d", tag, d), W'(lat[d]), W'(4 >> d));
      chk($sformatf("%s_valid%0d", tag, d), W'(ov[d]), W'(1));
      chk($sformatf("%s_vect%0d", tag, d), vo[d], ev);
      chk($sformatf("%s_pc%0d", tag, d), W'(pco[d]), W'(epc));
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    if (f) mflags = {z, n};
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_flags%0d", tag, d), W'(fo[d]), W'(mflags));
      chk($sformatf("%s_validdrop%0d", tag, d), W'(ov[d]), W'(0));
      chk($sformatf("%s_pcdrop%0d", tag, d), W'(pco[d]), W'(0));
    end
  endtask

  logic [VS-1:0][RS-1:0] ra, rb;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ovf = 1'b0; op = '0; pcsel = '0; v1 = '0; v2 = '0;
    mflags = 2'b00;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_vect", vo[d], '0);
      chk("rst_flags", W'(fo[d]), W'(0));
      chk("rst_valid", W'(ov[d]), W'(0));
      chk("rst_pc", W'(pco[d]), W'(0));
      chk("rst_ready", W'(ir[d]), W'(1));
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cycle();

    run_op("add_wrap", 3'd0, {32'd1, 32'hFFFF_FFFF, 32'd5, 32'd7},
           {32'd1, 32'd1, 32'hFFFF_FFFB, 32'd0}, 1'b1, 3'b000);
    chk("add_flags00", W'(fo[1]), W'(2'b00));
    run_op("zbr", 3'd1, {4{32'd3}}, {4{32'd3}}, 1'b1, 3'b010);
    chk("zbr_flags10", W'(fo[1]), W'(2'b10));
    run_op("nzbr", 3'd1, {4{32'd3}}, {4{32'd3}}, 1'b1, 3'b100);

    // Reset during BUSY discards the op and clears flags.
    start(3'd0, {4{32'd9}}, {4{32'd1}}, 1'b1, 3'b010);
    cycle();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rmid_vect", vo[d], '0);
      chk("rmid_flags", W'(fo[d]), W'(0));
      chk("rmid_valid", W'(ov[d]), W'(0));
      chk("rmid_ready", W'(ir[d]), W'(1));
    end
    #2 rst = 1'b0;
    mflags = 2'b00;
    cycle();

    run_op("n_noovf", 3'd1, {4{32'd0}}, {4{32'd1}}, 1'b0, 3'b001);

    // Flush in IDLE blocks acceptance.
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; ovf = 1'b1;
    #1 chk("flush_idle_ready", W'(ir[1]), W'(0));
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    repeat (6) cycle();
    chk("flush_idle_noaccept", W'(ov[0] | ov[1] | ov[2]), W'(0));

    // Flush in DONE with back-pressure: no commit, valid drops.
    start(3'd1, {4{32'd0}}, {4{32'd1}}, 1'b1, 3'b001);
    repeat (5) cycle();
    chk("fdone_valid", W'(ov[1]), W'(1));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("fdone_drop", W'(ov[d]), W'(0));
      chk("fdone_flags", W'(fo[d]), W'(mflags));
      chk("fdone_ready", W'(ir[d]), W'(1));
    end

    // Flush during BUSY of the slowest instance.
    start(3'd0, {4{32'd2}}, {4{32'd2}}, 1'b1, 3'b000);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (6) cycle();
    chk("fbusy_novalid", W'(ov[0] | ov[1]), W'(0));
    chk("fbusy_flags", W'(fo[0]), W'(mflags));

    run_op("mul_sweep", 3'd7, {4{32'h10000}}, {4{32'h10000}}, 1'b1, 3'b010);
    chk("mul_z", W'(fo[2][1]), W'(1));
    run_op("sll33", 3'd5, {32'h8000_0001, 32'd1, 32'd3, 32'hF0}, {4{32'd33}}, 1'b1, 3'b001);
    run_op("srl", 3'd6, {4{32'h8000_0000}}, {32'd31, 32'd1, 32'd0, 32'd63}, 1'b1, 3'b100);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < VS; k++) begin
        ra[k] = (t % 4 == 0) ? 32'(k) : $urandom;
        rb[k] = (t % 4 == 0) ? 32'(k) : $urandom;
      end
      run_op($sformatf("rnd%0d", t), 3'($urandom), ra, rb, 1'($urandom), 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
